// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_port_arbiter_pkg                                                 |
// | Shared types and constants for the IF/MEM unified memory arbiter.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package mem_port_arbiter_pkg;

  localparam int XLEN             = 32;
  localparam int ADDR_WIDTH       = 32;
  localparam int ARB_STARVE_LIMIT = 4;

  typedef logic [XLEN-1:0]       data_t;
  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef logic [3:0]            enable_t;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWNER_IF = 1'b0,
    OWNER_DM = 1'b1
  } arb_owner_t;

endpackage
`default_nettype wire

// File: rtl/mem_arb_pick.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_arb_pick                                                         |
// | Winner selection between fetch and data requests. Data has fixed     |
// | priority; a saturating starvation counter forces a fetch win once    |
// | fetch has lost STARVE_LIMIT arbitration cycles in a row.             |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module mem_arb_pick
  import mem_port_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = ARB_STARVE_LIMIT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic arb_en,     // arbiter is idle and may grant
  input  logic if_req,
  input  logic dm_req,
  input  logic if_block,   // flush: a fetch may not be granted this cycle
  output logic if_win,
  output logic dm_win
);

  logic [3:0] starve_cnt;
  logic       at_limit;
  logic       if_pick;

  assign at_limit = (starve_cnt == 4'(STARVE_LIMIT));
  // Fetch is preferred only when data is silent or fetch has starved.
  assign if_pick  = if_req & (~dm_req | at_limit);
  // A fetch picked during a flush is dropped, and data does not take its slot.
  assign if_win   = arb_en & if_pick & ~if_block;
  assign dm_win   = arb_en & dm_req & ~if_pick;

  // Count consecutive fetch losses, saturating; clear when fetch is granted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= 4'd0;
    end else if (if_win) begin
      starve_cnt <= 4'd0;
    end else if (dm_win && if_req && !at_limit) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_port_arbiter                                                     |
// | Shares one memory bus between the IF and MEM pipeline stages with    |
// | one outstanding transaction, data priority, fetch anti-starvation,   |
// | per-stage stalls and discard of flushed fetch responses.             |
// | Optional: define ARB_PERF_CNT_EN to add if_wait_cnt_o and            |
// | dm_xact_cnt_o performance counters.                                  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = ARB_STARVE_LIMIT
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    flush_i,
  input  logic    if_req_i,
  input  addr_t   if_addr_i,
  output logic    if_gnt_o,
  output logic    if_rvalid_o,
  output data_t   if_rdata_o,
  output logic    if_stall_o,
  input  logic    dm_req_i,
  input  logic    dm_we_i,
  input  enable_t dm_be_i,
  input  addr_t   dm_addr_i,
  input  data_t   dm_wdata_i,
  output logic    dm_gnt_o,
  output logic    dm_rvalid_o,
  output data_t   dm_rdata_o,
  output logic    dm_stall_o,
  output logic    mem_req_o,
  output logic    mem_we_o,
  output enable_t mem_be_o,
  output addr_t   mem_addr_o,
  output data_t   mem_wdata_o,
  input  logic    mem_gnt_i,
  input  logic    mem_rvalid_i,
  input  data_t   mem_rdata_i
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0] if_wait_cnt_o,
  output logic [31:0] dm_xact_cnt_o
`endif
);

  arb_state_t state;
  arb_owner_t owner;
  logic       discard;
  logic       if_win;
  logic       dm_win;
  logic       if_own;
  logic       dm_own;
  logic       rsp_ok;
  logic       drop;

  mem_arb_pick #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_pick (
    .clk      (clk),
    .rst_n    (rst_n),
    .arb_en   (state == ARB_IDLE),
    .if_req   (if_req_i),
    .dm_req   (dm_req_i),
    .if_block (flush_i),
    .if_win   (if_win),
    .dm_win   (dm_win)
  );

  assign if_gnt_o  = if_win;
  assign dm_gnt_o  = dm_win;
  assign mem_req_o = (state == ARB_ISSUE);

  assign if_own = (state != ARB_IDLE) && (owner == OWNER_IF);
  assign dm_own = (state != ARB_IDLE) && (owner == OWNER_DM);
  // Read data is only accepted while a transaction is waiting for it.
  assign rsp_ok = (state == ARB_WAIT) && mem_rvalid_i;
  // A flush coinciding with the response also kills the fetch.
  assign drop   = discard | flush_i;

  assign if_rvalid_o = rsp_ok & if_own & ~drop;
  assign if_rdata_o  = if_rvalid_o ? mem_rdata_i : '0;
  // Stores complete on bus acceptance; loads on returned data.
  assign dm_rvalid_o = dm_own & (rsp_ok | (mem_req_o & mem_gnt_i & mem_we_o));
  assign dm_rdata_o  = (dm_own && rsp_ok) ? mem_rdata_i : '0;

  assign if_stall_o = (if_req_i | if_own) & ~if_rvalid_o;
  assign dm_stall_o = (dm_req_i | dm_own) & ~dm_rvalid_o;

  // Transaction FSM: latch the winner, hold the bus request, await data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ARB_IDLE;
      owner       <= OWNER_IF;
      discard     <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_be_o    <= '0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          discard <= 1'b0;
          if (dm_win) begin
            owner       <= OWNER_DM;
            mem_we_o    <= dm_we_i;
            mem_be_o    <= dm_be_i;
            mem_addr_o  <= dm_addr_i;
            mem_wdata_o <= dm_wdata_i;
            state       <= ARB_ISSUE;
          end else if (if_win) begin
            owner       <= OWNER_IF;
            mem_we_o    <= 1'b0;
            mem_be_o    <= 4'hF;
            mem_addr_o  <= if_addr_i;
            mem_wdata_o <= '0;
            state       <= ARB_ISSUE;
          end
        end
        ARB_ISSUE: begin
          if (flush_i && owner == OWNER_IF) discard <= 1'b1;
          if (mem_gnt_i) state <= mem_we_o ? ARB_IDLE : ARB_WAIT;
        end
        ARB_WAIT: begin
          if (mem_rvalid_i) begin
            state   <= ARB_IDLE;
            discard <= 1'b0;
          end else if (flush_i && owner == OWNER_IF) begin
            discard <= 1'b1;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

`ifdef ARB_PERF_CNT_EN
  // Stall-cycle and completed-data-transaction counters, wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_wait_cnt_o <= 32'd0;
      dm_xact_cnt_o <= 32'd0;
    end else begin
      if (if_stall_o)  if_wait_cnt_o <= if_wait_cnt_o + 32'd1;
      if (dm_rvalid_o) dm_xact_cnt_o <= dm_xact_cnt_o + 32'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mem_port_arbiter                                                  |
// | Random-stimulus bench with a transaction-level reference model.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int LIMIT    = 4;
  localparam int N_CYCLES = 4000;

  logic    clk = 1'b0;
  logic    rst_n;
  logic    flush_i, if_req_i, dm_req_i, dm_we_i, mem_gnt_i, mem_rvalid_i;
  addr_t   if_addr_i, dm_addr_i;
  enable_t dm_be_i;
  data_t   dm_wdata_i, mem_rdata_i;
  logic    if_gnt_o, if_rvalid_o, if_stall_o, dm_gnt_o, dm_rvalid_o, dm_stall_o;
  logic    mem_req_o, mem_we_o;
  enable_t mem_be_o;
  addr_t   mem_addr_o;
  data_t   if_rdata_o, dm_rdata_o, mem_wdata_o;
`ifdef ARB_PERF_CNT_EN
  logic [31:0] if_wait_cnt_o, dm_xact_cnt_o;
  logic [31:0] m_wait, m_xact;
`endif

  mem_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o), .if_stall_o(if_stall_o),
    .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_be_i(dm_be_i),
    .dm_addr_i(dm_addr_i), .dm_wdata_i(dm_wdata_i), .dm_gnt_o(dm_gnt_o),
    .dm_rvalid_o(dm_rvalid_o), .dm_rdata_o(dm_rdata_o), .dm_stall_o(dm_stall_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
`ifdef ARB_PERF_CNT_EN
    , .if_wait_cnt_o(if_wait_cnt_o), .dm_xact_cnt_o(dm_xact_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: one transaction record plus the fetch loss count.
  bit      m_busy, m_if, m_store, m_acc, m_disc;
  int      m_starve;
  addr_t   m_addr;
  logic    m_we;
  enable_t m_be;
  data_t   m_wdata;
  bit      e_if_gnt, e_dm_gnt, e_ifv, e_dmv, e_ifst;
  bit      in_rst;

  task automatic clear_model();
    m_busy = 0; m_if = 0; m_store = 0; m_acc = 0; m_disc = 0; m_starve = 0;
`ifdef ARB_PERF_CNT_EN
    m_wait = 0; m_xact = 0;
`endif
  endtask

  task automatic check_cycle();
    bit if_pick, e_mreq, e_dmst;
    if_pick  = if_req_i && (!dm_req_i || m_starve == LIMIT);
    e_if_gnt = !m_busy && if_pick && !flush_i;
    e_dm_gnt = !m_busy && dm_req_i && !if_pick;
    e_mreq   = m_busy && !m_acc;
    e_ifv    = m_busy && m_acc && m_if && mem_rvalid_i && !m_disc;
    e_dmv    = m_busy && !m_if && ((m_acc && mem_rvalid_i) || (!m_acc && m_store && mem_gnt_i));
    e_ifst   = (if_req_i || (m_busy && m_if)) && !e_ifv;
    e_dmst   = (dm_req_i || (m_busy && !m_if)) && !e_dmv;
    check("if_gnt", if_gnt_o, e_if_gnt);
    check("dm_gnt", dm_gnt_o, e_dm_gnt);
    check("mem_req", mem_req_o, e_mreq);
    check("if_rvalid", if_rvalid_o, e_ifv);
    check("dm_rvalid", dm_rvalid_o, e_dmv);
    check("if_stall", if_stall_o, e_ifst);
    check("dm_stall", dm_stall_o, e_dmst);
    if (e_mreq) begin
      check("mem_addr", mem_addr_o, m_addr);
      check("mem_we", mem_we_o, m_we);
      if (!m_if) begin
        check("mem_be", mem_be_o, m_be);
        check("mem_wdata", mem_wdata_o, m_wdata);
      end
    end
    if (e_ifv) check("if_rdata", if_rdata_o, mem_rdata_i);
    else if (m_busy && !m_if) check("if_rdata_nonowner", if_rdata_o, 0);
    if (e_dmv && !m_store) check("dm_rdata", dm_rdata_o, mem_rdata_i);
    else if (m_busy && m_if) check("dm_rdata_nonowner", dm_rdata_o, 0);
    if (!rst_n) begin
      check("rst_mem_addr", mem_addr_o, 0);
      check("rst_mem_we", mem_we_o, 0);
      check("rst_mem_be", mem_be_o, 0);
      check("rst_mem_wdata", mem_wdata_o, 0);
      check("rst_if_rdata", if_rdata_o, 0);
      check("rst_dm_rdata", dm_rdata_o, 0);
    end
`ifdef ARB_PERF_CNT_EN
    check("if_wait_cnt", if_wait_cnt_o, m_wait);
    check("dm_xact_cnt", dm_xact_cnt_o, m_xact);
`endif
  endtask

  task automatic update_model();
    if (!rst_n) begin
      clear_model();
      return;
    end
`ifdef ARB_PERF_CNT_EN
    if (e_ifst) m_wait = m_wait + 1;
    if (e_dmv)  m_xact = m_xact + 1;
`endif
    if (!m_busy) begin
      if (e_dm_gnt) begin
        m_busy = 1; m_if = 0; m_acc = 0; m_disc = 0; m_store = dm_we_i;
        m_addr = dm_addr_i; m_we = dm_we_i; m_be = dm_be_i; m_wdata = dm_wdata_i;
        if (if_req_i && m_starve < LIMIT) m_starve++;
      end else if (e_if_gnt) begin
        m_busy = 1; m_if = 1; m_acc = 0; m_disc = 0; m_store = 0;
        m_addr = if_addr_i; m_we = 0; m_starve = 0;
      end
    end else if (!m_acc) begin
      if (m_if && flush_i) m_disc = 1;
      if (mem_gnt_i) begin
        if (m_store) m_busy = 0;
        else m_acc = 1;
      end
    end else begin
      if (mem_rvalid_i) m_busy = 0;
      else if (m_if && flush_i) m_disc = 1;
    end
  endtask

  task automatic drive(input int cyc);
    int dm_pct;
    dm_pct = (cyc < N_CYCLES / 2) ? 85 : 40;
    if (!in_rst && m_busy && m_acc && $urandom_range(0, 39) == 0) begin
      // Reset in the middle of a transaction waiting for data.
      in_rst = 1;
      rst_n = 0;
      flush_i = 0; if_req_i = 0; dm_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 0;
      clear_model();
      return;
    end
    if (!(if_req_i && !e_if_gnt)) begin
      if_req_i  = ($urandom_range(0, 99) < 60);
      if_addr_i = $urandom & 32'hFFFF_FFFC;
    end
    if (!(dm_req_i && !e_dm_gnt)) begin
      dm_req_i   = ($urandom_range(0, 99) < dm_pct);
      dm_we_i    = $urandom_range(0, 1) == 1;
      dm_be_i    = 4'($urandom);
      dm_addr_i  = $urandom & 32'hFFFF_FFFC;
      dm_wdata_i = $urandom;
    end
    flush_i      = ($urandom_range(0, 99) < 8);
    mem_gnt_i    = $urandom_range(0, 1) == 1;
    mem_rvalid_i = ($urandom_range(0, 99) < 50) && !flush_i;
    mem_rdata_i  = $urandom;
    if (in_rst) begin
      // Release reset with a stale response on the bus; it must be ignored.
      in_rst = 0;
      rst_n = 1;
      mem_rvalid_i = 1;
    end
  endtask

  initial begin
    rst_n = 0; in_rst = 0;
    flush_i = 0; if_req_i = 0; dm_req_i = 0; dm_we_i = 0; mem_gnt_i = 0; mem_rvalid_i = 0;
    if_addr_i = '0; dm_addr_i = '0; dm_be_i = '0; dm_wdata_i = '0; mem_rdata_i = '0;
    e_if_gnt = 0; e_dm_gnt = 0; e_ifv = 0; e_dmv = 0; e_ifst = 0;
    clear_model();
    @(negedge clk);
    check_cycle();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    for (int cyc = 0; cyc < N_CYCLES; cyc++) begin
      @(negedge clk);
      check_cycle();
      @(posedge clk);
      update_model();
      #1;
      drive(cyc);
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
